conv3x3_mac_acc: RTL

Parametrised 3x3 convolution MAC engine. Each valid beat supplies one input channel as a 4x4 tile and a 3x3 kernel, and the block produces the four stride-1 outputs of a 2x2 output tile. It accumulates those outputs over NUM_CH channels, or fewer if a beat is flagged last, then applies an arithmetic right shift, optional ReLU and saturation before emitting one result. It replaces the fixed 8-bit single-shot mac in the feature-extraction datapath and sits between the line-buffer tile fetcher and the output writeback.

---
 rtl/conv3x3_mac_acc.sv | 137 +++++++++++++
 1 files changed

// File: rtl/conv3x3_mac_acc.sv
// 3x3 convolution MAC over a 4x4 tile producing a 2x2 output tile, accumulated
// across channel beats, then shifted, optionally rectified and saturated.
module conv3x3_mac_acc #(
    parameter int DW     = 8,
    parameter int ACC_W  = 24,
    parameter int NUM_CH = 3,
    parameter int SHIFT  = 0,
    parameter int OUT_W  = 8,
    parameter int RELU   = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 vld_i,
    input  logic [16*DW-1:0]     iDin,
    input  logic [9*DW-1:0]      iWeight,
    input  logic                 iLast,
    output logic                 oVld,
    output logic [4*OUT_W-1:0]   oOut,
    output logic [3:0]           oSat
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = 2 * DW;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((longint'(1) <<< (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    logic signed [PW-1:0]    prod_d [4][9];
    logic signed [PW-1:0]    prod_q [4][9];
    logic signed [ACC_W-1:0] sum_d  [4];
    logic signed [ACC_W-1:0] sum_q  [4];
    logic signed [ACC_W-1:0] acc_d  [4];
    logic signed [ACC_W-1:0] acc_q  [4];
    logic signed [ACC_W-1:0] fin_t  [4];
    logic [CW-1:0]           ch_cnt_d, ch_cnt_q;
    logic                    close_d;
    logic                    s1_vld_q, s1_close_q, s1_first_q;
    logic                    s2_vld_q, s2_close_q, s2_first_q;
    logic                    s3_vld_q, s3_close_q;
    logic [4*OUT_W-1:0]      out_d, out_q;
    logic [3:0]              sat_d, sat_q;
    logic                    vld_q;

    // Window k takes its origin at row k>>1, column k&1 of the tile.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            for (int kr = 0; kr < 3; kr++) begin
                for (int kc = 0; kc < 3; kc++) begin
                    prod_d[k][kr*3+kc] =
                        PW'($signed(iDin[(((k >> 1) + kr) * 4 + (k & 1) + kc) * DW +: DW])) *
                        PW'($signed(iWeight[(kr * 3 + kc) * DW +: DW]));
                end
            end
        end
    end

    always_comb begin
        close_d  = (ch_cnt_q == CW'(NUM_CH - 1)) || iLast;
        ch_cnt_d = ch_cnt_q;
        if (vld_i) begin
            ch_cnt_d = close_d ? '0 : ch_cnt_q + CW'(1);
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            sum_d[k] = '0;
            for (int i = 0; i < 9; i++) begin
                sum_d[k] = sum_d[k] + ACC_W'(prod_q[k][i]);
            end
            acc_d[k] = s2_first_q ? sum_q[k] : acc_q[k] + sum_q[k];
        end
    end

    always_comb begin
        out_d = '0;
        sat_d = '0;
        for (int k = 0; k < 4; k++) begin
            fin_t[k] = acc_q[k] >>> SHIFT;
            if (RELU != 0 && fin_t[k] < 0) begin
                fin_t[k] = '0;
            end
            if (fin_t[k] > MAXV) begin
                out_d[k*OUT_W +: OUT_W] = OUT_W'(MAXV);
                sat_d[k]                = 1'b1;
            end else if (fin_t[k] < MINV) begin
                out_d[k*OUT_W +: OUT_W] = OUT_W'(MINV);
                sat_d[k]                = 1'b1;
            end else begin
                out_d[k*OUT_W +: OUT_W] = OUT_W'(fin_t[k]);
            end
        end
    end

    // First-of-group is decided at acceptance so that a close is always followed by a load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < 9; i++) prod_q[k][i] <= '0;
                sum_q[k] <= '0;
                acc_q[k] <= '0;
            end
            ch_cnt_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_close_q <= 1'b0;
            s1_first_q <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_close_q <= 1'b0;
            s2_first_q <= 1'b0;
            s3_vld_q   <= 1'b0;
            s3_close_q <= 1'b0;
            out_q      <= '0;
            sat_q      <= '0;
            vld_q      <= 1'b0;
        end else begin
            prod_q     <= prod_d;
            ch_cnt_q   <= ch_cnt_d;
            s1_vld_q   <= vld_i;
            s1_close_q <= close_d;
            s1_first_q <= (ch_cnt_q == '0);
            sum_q      <= sum_d;
            s2_vld_q   <= s1_vld_q;
            s2_close_q <= s1_close_q;
            s2_first_q <= s1_first_q;
            if (s2_vld_q) acc_q <= acc_d;
            s3_vld_q   <= s2_vld_q;
            s3_close_q <= s2_close_q;
            vld_q      <= s3_vld_q && s3_close_q;
            if (s3_vld_q && s3_close_q) begin
                out_q <= out_d;
                sat_q <= sat_d;
            end
        end
    end

    assign oVld = vld_q;
    assign oOut = out_q;
    assign oSat = sat_q;
endmodule
